play_mode_scheduler: RTL

Top-level sequencer that shares the single buzzer between three note sources: free-play keyboard, auto-play engine and learn-mode engine. Mode changes are committed only by a confirm pulse and always pass through a muted gap. The block also selects the song base address for note memory, restarts the auto-play engine, and detects end-of-song from the engine's memory index. It sits between the mode/song switches and the buzzer tone generator.

---
 rtl/play_mode_scheduler_pkg.sv | 41 ++++
 rtl/play_mode_scheduler_if.sv | 35 +++
 rtl/play_mode_scheduler_mute_gap_timer.sv | 40 ++++
 rtl/play_mode_scheduler.sv | 138 +++++++++++++
 4 files changed

// File: rtl/play_mode_scheduler_pkg.sv
// Shared encodings for the play-mode scheduler: modes, FSM states and song geometry.
`default_nettype none

package play_mode_scheduler_pkg;

  localparam logic [1:0] MODE_IDLE  = 2'd0;
  localparam logic [1:0] MODE_FREE  = 2'd1;
  localparam logic [1:0] MODE_AUTO  = 2'd2;
  localparam logic [1:0] MODE_LEARN = 2'd3;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_MUTE  = 3'd1;
  localparam state_t ST_FREE  = 3'd2;
  localparam state_t ST_AUTO  = 3'd3;
  localparam state_t ST_LEARN = 3'd4;

  localparam int SONG_LEN_DEF = 26;
  localparam int SLOT_W_DEF   = 5;

  function automatic state_t mode_to_state(input logic [1:0] mode);
    case (mode)
      MODE_FREE:  return ST_FREE;
      MODE_AUTO:  return ST_AUTO;
      MODE_LEARN: return ST_LEARN;
      default:    return ST_IDLE;
    endcase
  endfunction

  function automatic logic [1:0] state_to_mode(input state_t st);
    case (st)
      ST_FREE:  return MODE_FREE;
      ST_AUTO:  return MODE_AUTO;
      ST_LEARN: return MODE_LEARN;
      default:  return MODE_IDLE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/play_mode_scheduler_if.sv
// Mode/song controls, the three note sources and the buzzer-side outputs of the scheduler.
`default_nettype none

interface play_mode_scheduler_if;
  logic [1:0] mode_sel;
  logic [1:0] song_sel;
  logic       confirm;
  logic       free_on;
  logic [3:0] free_key;
  logic       auto_on;
  logic [3:0] auto_key;
  logic [4:0] auto_idx;
  logic       learn_on;
  logic [3:0] learn_key;
  logic       buzzer_on;
  logic [3:0] buzzer_key;
  logic [1:0] active_mode;
  logic       engine_rst;
  logic [6:0] song_base;
  logic       song_done;

  modport master (
    output mode_sel, song_sel, confirm, free_on, free_key,
           auto_on, auto_key, auto_idx, learn_on, learn_key,
    input  buzzer_on, buzzer_key, active_mode, engine_rst, song_base, song_done
  );

  modport slave (
    input  mode_sel, song_sel, confirm, free_on, free_key,
           auto_on, auto_key, auto_idx, learn_on, learn_key,
    output buzzer_on, buzzer_key, active_mode, engine_rst, song_base, song_done
  );
endinterface

`default_nettype wire

// File: rtl/play_mode_scheduler_mute_gap_timer.sv
// Mute gap timer: clear restarts the gap, done_o flags the last of GAP_CYCLES running cycles.
`default_nettype none

module mute_gap_timer #(
  parameter int GAP_CYCLES = 5000000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clear_i,
  input  wire logic run_i,
  output logic      done_o
);

  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(GAP_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign done_o = run_i && !clear_i && (cnt_q == C_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || done_o) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/play_mode_scheduler.sv
// Buzzer-sharing sequencer for free/auto/learn note sources with a muted gap on every mode change.
// Build option: AUTO_LOOP_EN makes auto mode repeat the song instead of returning to idle.
`default_nettype none

module play_mode_scheduler
  import play_mode_scheduler_pkg::*;
#(
  parameter int GAP_CYCLES = 5000000,
  parameter int SONG_LEN   = SONG_LEN_DEF,
  parameter int SLOT_W     = SLOT_W_DEF
) (
  input wire logic            clk,
  input wire logic            rst,
  play_mode_scheduler_if.slave bus
);

  // auto_idx is 5 bits wide, so SONG_LEN must stay below 32.
  localparam logic [4:0] C_IDX_LAST = 5'(SONG_LEN - 1);
  localparam logic [4:0] C_IDX_LEN  = 5'(SONG_LEN);

  state_t     state_q, state_d;
  logic [1:0] target_q, target_d;
  logic [6:0] base_q, base_d;
  logic [4:0] prev_idx_q, prev_idx_d;
  logic       erst_q, erst_d;
  logic       done_q, done_d;
  logic       on_q, on_d;
  logic [3:0] key_q, key_d;
  logic [1:0] mode_q, mode_d;

  logic       gap_done;
  logic       end_of_song;

  mute_gap_timer #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_gap (
    .clk     (clk),
    .rst     (rst),
    .clear_i (bus.confirm),
    .run_i   (state_q == ST_MUTE),
    .done_o  (gap_done)
  );

  // Previous index is forced to 0 outside AUTO so a stale value cannot fake a wrap.
  assign end_of_song = (state_q == ST_AUTO) &&
                       (((prev_idx_q == C_IDX_LAST) && (bus.auto_idx == 5'd0)) ||
                        (bus.auto_idx >= C_IDX_LEN));

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    base_d     = base_q;
    erst_d     = 1'b0;
    done_d     = end_of_song;
    prev_idx_d = (state_q == ST_AUTO) ? bus.auto_idx : 5'd0;

    case (state_q)
      ST_MUTE: begin
        if (gap_done) begin
          state_d = mode_to_state(target_q);
        end
      end
      ST_AUTO: begin
        if (end_of_song) begin
`ifdef AUTO_LOOP_EN
          erst_d = 1'b1;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: begin
      end
    endcase

    if (bus.confirm) begin
      state_d  = ST_MUTE;
      target_d = bus.mode_sel;
      base_d   = 7'(bus.song_sel) << SLOT_W;
      erst_d   = 1'b1;
    end

    // Buzzer follows the owner of the next state, giving exactly GAP_CYCLES muted cycles.
    on_d  = 1'b0;
    key_d = 4'd0;
    case (state_d)
      ST_FREE: begin
        on_d  = bus.free_on;
        key_d = bus.free_key;
      end
      ST_AUTO: begin
        on_d  = bus.auto_on;
        key_d = bus.auto_key;
      end
      ST_LEARN: begin
        on_d  = bus.learn_on;
        key_d = bus.learn_key;
      end
      default: begin
      end
    endcase
    mode_d = state_to_mode(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      target_q   <= MODE_IDLE;
      base_q     <= 7'd0;
      prev_idx_q <= 5'd0;
      erst_q     <= 1'b0;
      done_q     <= 1'b0;
      on_q       <= 1'b0;
      key_q      <= 4'd0;
      mode_q     <= MODE_IDLE;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      base_q     <= base_d;
      prev_idx_q <= prev_idx_d;
      erst_q     <= erst_d;
      done_q     <= done_d;
      on_q       <= on_d;
      key_q      <= key_d;
      mode_q     <= mode_d;
    end
  end

  assign bus.buzzer_on   = on_q;
  assign bus.buzzer_key  = key_q;
  assign bus.active_mode = mode_q;
  assign bus.engine_rst  = erst_q;
  assign bus.song_base   = base_q;
  assign bus.song_done   = done_q;

endmodule

`default_nettype wire
